result_ram_writer: RTL and testbench
====================================

Name: result_ram_writer

Overview:
- Write-back end of the matrix-multiply datapath.
- Accepts computed result words from the ALU over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO into the result SRAM at consecutive addresses.
- Pulses ram_done once a full result matrix has been written; this is the RAM-completion handshake the sequencing controller waits on.

Parameters:
- DW, 32, result word / SRAM data width in bits
- AW, 8, SRAM address width
- BASE_ADDR, 0, first SRAM address written per job
- RES_COUNT, 16, result words per job (4 columns x 4 rows)
- FIFO_DEPTH, 4, buffer entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: arm a new job
- res_valid  in  1  ALU result word valid
- res_data  in  DW  ALU result word
- res_ready  out  1  writer can accept res_data this cycle
- ram_csn  out  1  SRAM chip select, active-low
- ram_wen  out  1  SRAM write enable, active-low
- ram_addr  out  AW  SRAM address
- ram_din  out  DW  SRAM write data
- ram_done  out  1  one-cycle pulse, job fully written
- busy  out  1  high from accepted start until ram_done pulse

Behaviour:
- Reset (async, rst=1):
  - State IDLE; FIFO empty; accept and write counters 0.
  - Outputs: res_ready=0, ram_csn=1, ram_wen=1, ram_addr=0, ram_din=0, ram_done=0, busy=0.
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 -> RUN; clear counters and FIFO. res_ready=0.
  - RUN: accept and drain concurrently. When the write counter reaches RES_COUNT and the last write has been issued -> DONE.
  - DONE: ram_done=1 for exactly one cycle, busy=0 -> IDLE.
  - start while in RUN or DONE is ignored.
- Accept side:
  - res_ready = (state==RUN) && FIFO not full && accept_cnt < RES_COUNT. Computed combinationally from registered state only; it never depends on res_valid.
  - A transfer occurs when res_valid && res_ready. The word is pushed and accept_cnt is incremented.
  - Words offered after RES_COUNT have been accepted see res_ready=0 and are not consumed.
- Write side (all SRAM outputs registered):
  - In RUN, each cycle the FIFO is non-empty, pop the head and drive ram_csn=0, ram_wen=0, ram_addr=BASE_ADDR+wr_cnt, ram_din=head on the next edge. Then increment wr_cnt.
  - If the FIFO is empty: ram_csn=1, ram_wen=1; ram_addr and ram_din hold their last values.
  - One write per cycle maximum.
- Latency: a word accepted at edge N into an empty FIFO appears on the SRAM pins after edge N+1.
- Throughput: 1 word/cycle sustained. With continuous res_valid, the FIFO never exceeds 1 entry.
- Simultaneous push and pop on the same cycle is legal; occupancy is unchanged. Full is checked against registered occupancy, so no push occurs when full even if a pop happens that cycle.
- Address arithmetic:
  - BASE_ADDR+wr_cnt is computed modulo 2^AW and wraps silently.
  - RES_COUNT > 2^AW is a configuration error and is not checked.
- ram_done:
  - Asserted the cycle after the final SRAM write cycle (ram_wen=0 with wr_cnt=RES_COUNT-1).
  - Never asserted outside DONE.
- Reset mid-job: everything returns to reset values immediately. Buffered words are discarded, no partial ram_done is issued, and a fresh start is required.

Test Plan:
- Reset, then start pulse, then 16 back-to-back valid words 0x100..0x10F -> 16 consecutive SRAM writes at addr 0..15 with din 0x100..0x10F; write k occurs 1 cycle after accept k; ram_done pulses once, on the cycle after addr 15; busy falls with it.
- res_valid held high but gaps on the write side impossible, so instead inject valid with bubbles (valid every 3rd cycle) -> writes occur only on the cycle after each accept; ram_csn=1 in between; addresses still 0..15 contiguous.
- BASE_ADDR=250, AW=8, RES_COUNT=16 -> addresses 250..255 then wrap to 0..9; ram_done after addr 9.
- After 16 accepts, keep res_valid=1 with data 0xDEAD -> res_ready stays 0, no 17th write, ram_done pulses exactly once.
- start pulse while busy (after 5 writes) -> ignored; counters continue 5..15, single ram_done.
- Assert rst after 7 writes with FIFO non-empty -> next cycle ram_csn=1, ram_wen=1, res_ready=0, busy=0, no ram_done. A new start then writes from BASE_ADDR again.

Source files
------------

// File: rtl/result_ram_writer_if.sv
// Result write-back bus: ALU result handshake in, SRAM write port and job status out.
//   start      : one-cycle pulse that arms a new job
//   res_valid  : ALU result word valid
//   res_data   : ALU result word
//   res_ready  : writer can take res_data this cycle
//   ram_csn    : SRAM chip select, active-low
//   ram_wen    : SRAM write enable, active-low
//   ram_addr   : SRAM address
//   ram_din    : SRAM write data
//   ram_done   : one-cycle pulse, job fully written
//   busy       : job in progress
// slave  = the writer, master = the ALU/controller side driving it.
interface result_ram_writer_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
);
  logic          start;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;
  logic          ram_csn;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_done;
  logic          busy;

  modport slave (
    input  start, res_valid, res_data,
    output res_ready, ram_csn, ram_wen, ram_addr, ram_din, ram_done, busy
  );

  modport master (
    output start, res_valid, res_data,
    input  res_ready, ram_csn, ram_wen, ram_addr, ram_din, ram_done, busy
  );
endinterface

// File: rtl/result_ram_writer.sv
// Write-back end of the matrix-multiply datapath. Buffers ALU result words in a
// small FIFO and drains them into the result SRAM at consecutive addresses,
// pulsing ram_done once RES_COUNT words of a job have been written.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : result_ram_writer_if.slave (handshake in, SRAM port and status out)
module result_ram_writer #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned RES_COUNT  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  result_ram_writer_if.slave  bus
);

  localparam int unsigned CW = $clog2(RES_COUNT + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_acc_cnt;
  logic [CW-1:0] r_wr_cnt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [OW-1:0] r_count;
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic          r_csn;
  logic          r_wen;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic          r_done;
  logic          r_busy;

  logic          w_full;
  logic          w_empty;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_addr;

  // Full is judged on registered occupancy, so a same-cycle pop never frees a slot early.
  assign w_full  = (r_count == OW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_ready = (r_state == S_RUN) && !w_full && (r_acc_cnt < CW'(RES_COUNT));
  assign w_push  = bus.res_valid && w_ready;
  assign w_pop   = (r_state == S_RUN) && !w_empty;
  // Address wraps modulo 2^AW.
  assign w_addr  = AW'(BASE_ADDR) + AW'(r_wr_cnt);

  // FIFO storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.res_data;
  end

  // Job FSM, FIFO bookkeeping and registered SRAM port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_csn     <= 1'b1;
      r_wen     <= 1'b1;
      r_addr    <= '0;
      r_din     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_csn  <= 1'b1;
      r_wen  <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_acc_cnt <= '0;
            r_wr_cnt  <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
          end
        end
        S_RUN: begin
          if (w_push) begin
            r_wr_ptr  <= r_wr_ptr + PW'(1);
            r_acc_cnt <= r_acc_cnt + CW'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_csn    <= 1'b0;
            r_wen    <= 1'b0;
            r_addr   <= w_addr;
            r_din    <= r_mem[r_rd_ptr];
            r_wr_cnt <= r_wr_cnt + CW'(1);
          end
          r_count <= r_count + OW'(w_push) - OW'(w_pop);
          // wr_cnt reaches RES_COUNT on the edge that issued the last write.
          if (r_wr_cnt == CW'(RES_COUNT)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.res_ready = w_ready;
  assign bus.ram_csn   = r_csn;
  assign bus.ram_wen   = r_wen;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_din   = r_din;
  assign bus.ram_done  = r_done;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_result_ram_writer.sv
// Bench for result_ram_writer: two instances (BASE_ADDR 0 and 250) share one
// stimulus stream; a transaction-level model predicts each output cycle by cycle.
module tb_result_ram_writer;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 8;
  localparam int          RES    = 16;
  localparam int unsigned BASE_B = 250;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_ram_writer_if #(.DW(DW), .AW(AW)) bus   ();
  result_ram_writer_if #(.DW(DW), .AW(AW)) bus_b ();

  assign bus_b.start     = bus.start;
  assign bus_b.res_valid = bus.res_valid;
  assign bus_b.res_data  = bus.res_data;

  result_ram_writer #(.DW(DW), .AW(AW), .BASE_ADDR(0), .RES_COUNT(RES), .FIFO_DEPTH(4))
    u_dut (.clk(clk), .rst(rst), .bus(bus));

  result_ram_writer #(.DW(DW), .AW(AW), .BASE_ADDR(BASE_B), .RES_COUNT(RES), .FIFO_DEPTH(4))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: word k accepted at edge N is written at edge N+1; done follows the last write by one edge.
  bit            m_busy, cur_wr, cur_done, tr_prev;
  int            m_acc, cur_idx, idx_prev, done_cnt;
  logic [DW-1:0] data_prev, exp_din;
  logic [AW-1:0] exp_addr, exp_addr_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; cur_wr = 0; cur_done = 0; tr_prev = 0;
    m_acc = 0; cur_idx = 0; idx_prev = 0;
    data_prev = '0; exp_din = '0; exp_addr = '0; exp_addr_b = '0;
  endtask

  // One clock: check the state left by the last edge, then drive the next one.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic s);
    bit tr, nxt_done;
    @(negedge clk);
    check("res_ready",  64'(bus.res_ready),  64'(m_busy && (m_acc < RES)));
    check("ram_csn",    64'(bus.ram_csn),    64'(!cur_wr));
    check("ram_wen",    64'(bus.ram_wen),    64'(!cur_wr));
    check("ram_addr",   64'(bus.ram_addr),   64'(exp_addr));
    check("ram_din",    64'(bus.ram_din),    64'(exp_din));
    check("ram_done",   64'(bus.ram_done),   64'(cur_done));
    check("busy",       64'(bus.busy),       64'(m_busy));
    check("ram_csn_b",  64'(bus_b.ram_csn),  64'(!cur_wr));
    check("ram_addr_b", 64'(bus_b.ram_addr), 64'(exp_addr_b));

    tr       = v && m_busy && (m_acc < RES);
    nxt_done = cur_wr && (cur_idx == RES - 1);
    cur_wr   = tr_prev;
    cur_idx  = idx_prev;
    if (tr_prev) begin
      exp_addr   = AW'(idx_prev);
      exp_addr_b = AW'(BASE_B + 32'(idx_prev));
      exp_din    = data_prev;
    end
    if (s && !m_busy && !cur_done) begin
      m_busy = 1;
      m_acc  = 0;
    end
    if (nxt_done) begin
      m_busy = 0;
      done_cnt++;
    end
    cur_done  = nxt_done;
    tr_prev   = tr;
    data_prev = d;
    idx_prev  = m_acc;
    if (tr) m_acc++;

    bus.res_valid = v;
    bus.res_data  = d;
    bus.start     = s;
  endtask

  // Async reset mid-cycle; outputs must drop without waiting for an edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    bus.res_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_csn",   64'(bus.ram_csn),   64'(1));
    check("rst_wen",   64'(bus.ram_wen),   64'(1));
    check("rst_ready", 64'(bus.res_ready), 64'(0));
    check("rst_busy",  64'(bus.busy),      64'(0));
    check("rst_done",  64'(bus.ram_done),  64'(0));
    check("rst_addr",  64'(bus.ram_addr),  64'(0));
    check("rst_din",   64'(bus.ram_din),   64'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: back-to-back then 0xDEAD flood; 1: valid every 3rd cycle;
  // 2: random valid/data/start; 3: back-to-back with start after 5 writes.
  task automatic run_job(input int mode, input int stop_at);
    int            done0;
    int            tail;
    int            k;
    bit            fin;
    logic          v, s;
    logic [DW-1:0] d;
    done0 = done_cnt;
    tail  = 0;
    k     = 0;
    fin   = 0;
    cycle(1'b0, '0, 1'b1);
    while (!fin) begin
      s = 1'b0;
      d = (m_acc < RES) ? DW'(32'h100 + 32'(m_acc)) : DW'(32'hDEAD);
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 3 == 0);
        2: begin
          v = 1'($urandom_range(0, 1));
          d = $urandom;
          s = ($urandom_range(0, 7) == 0);
        end
        default: begin
          v = 1'b1;
          s = cur_wr && (cur_idx == 4);
        end
      endcase
      if (done_cnt != done0) begin
        s = 1'b0;
        tail++;
      end
      cycle(v, d, s);
      k++;
      if (tail >= 4) fin = 1;
      if (stop_at > 0 && cur_wr && cur_idx == stop_at - 1) fin = 1;
      if (k > 400) begin
        check("job_timeout", 64'(0), 64'(1));
        fin = 1;
      end
    end
    if (stop_at == 0) check("done_count", 64'(done_cnt - done0), 64'(1));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    done_cnt = 0;
    model_clear();
    do_reset();
    run_job(0, 0);
    run_job(1, 0);
    run_job(3, 0);
    run_job(0, 7);
    do_reset();
    cycle(1'b0, '0, 1'b0);
    run_job(0, 0);
    for (int i = 0; i < 4; i++) run_job(2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
